// File: rtl/soin_bpredictor_resolve_queue.sv
// In-order queue of predicted branches awaiting resolution in execute.
// Produces registered predictor update/recovery and fetch redirect on resolve.
module soin_bpredictor_resolve_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned RAS_W  = 4,
    parameter int unsigned META_W = 22
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    input  logic [31:0]               enq_PC,
    input  logic                      enq_p_dir,
    input  logic [31:0]               enq_p_target,
    input  logic [META_W-1:0]         enq_meta,
    output logic                      enq_ready,
    output logic                      soin_bpredictor_stall,
    input  logic                      res_valid,
    input  logic                      res_dir,
    input  logic [31:0]               res_target,
    output logic                      execute_bpredictor_update,
    output logic [31:0]               execute_bpredictor_PC,
    output logic [31:0]               execute_bpredictor_target,
    output logic                      execute_bpredictor_dir,
    output logic                      execute_bpredictor_miss,
    output logic [META_W-1:0]         execute_bpredictor_meta,
    output logic                      execute_bpredictor_recover_ras,
    output logic                      fetch_redirect,
    output logic [31:0]               fetch_redirect_PC,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      res_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    logic [31:0]       pc_mem   [DEPTH];
    logic              pdir_mem [DEPTH];
    logic [31:0]       ptgt_mem [DEPTH];
    logic [META_W-1:0] meta_mem [DEPTH];

    logic [PTR_W:0]    head;
    logic [PTR_W:0]    tail;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              empty;
    logic              do_enq;
    logic              do_res;

    logic [PTR_W-1:0]  head_idx;
    logic [PTR_W-1:0]  tail_idx;
    logic [31:0]       h_pc;
    logic              h_pdir;
    logic [31:0]       h_ptgt;
    logic [META_W-1:0] h_meta;
    logic [1:0]        old_ctr;
    logic [1:0]        new_ctr;
    logic              miss_c;
    logic [META_W-1:0] new_meta;

    assign full                  = (count_q == FULL_CNT);
    assign empty                 = (count_q == '0);
    assign enq_ready             = ~full;
    assign soin_bpredictor_stall = full;
    assign count                 = count_q;

    assign do_enq = enq_valid & ~full;
    assign do_res = res_valid & ~empty;

    assign head_idx = head[PTR_W-1:0];
    assign tail_idx = tail[PTR_W-1:0];
    assign h_pc     = pc_mem[head_idx];
    assign h_pdir   = pdir_mem[head_idx];
    assign h_ptgt   = ptgt_mem[head_idx];
    assign h_meta   = meta_mem[head_idx];
    assign old_ctr  = h_meta[IDX_W+1:IDX_W];

    assign miss_c   = (res_dir != h_pdir) | (res_dir & (res_target != h_ptgt));
    assign new_meta = {h_meta[META_W-1:IDX_W+2], new_ctr, h_meta[IDX_W-1:0]};

    always_comb begin
        new_ctr = old_ctr;
        if (res_dir) begin
            if (old_ctr != 2'd3) new_ctr = old_ctr + 2'd1;
        end else begin
            if (old_ctr != 2'd0) new_ctr = old_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem[tail_idx]   <= enq_PC;
            pdir_mem[tail_idx] <= enq_p_dir;
            ptgt_mem[tail_idx] <= enq_p_target;
            meta_mem[tail_idx] <= enq_meta;
        end
    end

    // A mispredict collapses the queue onto the slot after the resolved head,
    // which also discards any same-cycle (wrong-path) enqueue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count_q       <= '0;
            res_underflow <= 1'b0;
        end else begin
            if (do_res && miss_c) begin
                head    <= head + PTR_ONE;
                tail    <= head + PTR_ONE;
                count_q <= '0;
            end else begin
                if (do_res) head <= head + PTR_ONE;
                if (do_enq) tail <= tail + PTR_ONE;
                count_q <= count_q + CNT_W'(do_enq) - CNT_W'(do_res);
            end
            if (res_valid && empty) res_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            execute_bpredictor_update      <= 1'b0;
            execute_bpredictor_PC          <= '0;
            execute_bpredictor_target      <= '0;
            execute_bpredictor_dir         <= 1'b0;
            execute_bpredictor_miss        <= 1'b0;
            execute_bpredictor_meta        <= '0;
            execute_bpredictor_recover_ras <= 1'b0;
            fetch_redirect                 <= 1'b0;
            fetch_redirect_PC              <= '0;
        end else begin
            execute_bpredictor_update      <= do_res;
            execute_bpredictor_recover_ras <= do_res & miss_c;
            fetch_redirect                 <= do_res & miss_c;
            if (do_res) begin
                execute_bpredictor_PC     <= h_pc;
                execute_bpredictor_target <= res_target;
                execute_bpredictor_dir    <= res_dir;
                execute_bpredictor_miss   <= miss_c;
                execute_bpredictor_meta   <= new_meta;
                if (miss_c) fetch_redirect_PC <= res_target;
            end
        end
    end

endmodule

// File: tb/tb_soin_bpredictor_resolve_queue.sv
// Directed bench for the resolve queue with a queue-based reference model
// compared against the DUT on every falling edge.
module tb_soin_bpredictor_resolve_queue;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 16;
    localparam int RAS_W  = 4;
    localparam int META_W = 22;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enq_valid = 1'b0;
    logic [31:0]       enq_PC = '0;
    logic              enq_p_dir = 1'b0;
    logic [31:0]       enq_p_target = '0;
    logic [META_W-1:0] enq_meta = '0;
    logic              enq_ready;
    logic              soin_bpredictor_stall;
    logic              res_valid = 1'b0;
    logic              res_dir = 1'b0;
    logic [31:0]       res_target = '0;
    logic              execute_bpredictor_update;
    logic [31:0]       execute_bpredictor_PC;
    logic [31:0]       execute_bpredictor_target;
    logic              execute_bpredictor_dir;
    logic              execute_bpredictor_miss;
    logic [META_W-1:0] execute_bpredictor_meta;
    logic              execute_bpredictor_recover_ras;
    logic              fetch_redirect;
    logic [31:0]       fetch_redirect_PC;
    logic [3:0]        count;
    logic              res_underflow;

    soin_bpredictor_resolve_queue #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .RAS_W(RAS_W), .META_W(META_W)
    ) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_PC(enq_PC), .enq_p_dir(enq_p_dir),
        .enq_p_target(enq_p_target), .enq_meta(enq_meta), .enq_ready(enq_ready),
        .soin_bpredictor_stall(soin_bpredictor_stall),
        .res_valid(res_valid), .res_dir(res_dir), .res_target(res_target),
        .execute_bpredictor_update(execute_bpredictor_update),
        .execute_bpredictor_PC(execute_bpredictor_PC),
        .execute_bpredictor_target(execute_bpredictor_target),
        .execute_bpredictor_dir(execute_bpredictor_dir),
        .execute_bpredictor_miss(execute_bpredictor_miss),
        .execute_bpredictor_meta(execute_bpredictor_meta),
        .execute_bpredictor_recover_ras(execute_bpredictor_recover_ras),
        .fetch_redirect(fetch_redirect), .fetch_redirect_PC(fetch_redirect_PC),
        .count(count), .res_underflow(res_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [META_W-1:0] mk(input int ras, input int ctr, input int idx);
        logic [3:0]  r = 4'(ras);
        logic [1:0]  c = 2'(ctr);
        logic [15:0] i = 16'(idx);
        return {r, c, i};
    endfunction

    // Reference model: a list of pending branches plus the last reported outputs.
    typedef struct {
        logic [31:0]       pc;
        logic              dir;
        logic [31:0]       tgt;
        logic [META_W-1:0] meta;
    } ent_t;

    ent_t              q[$];
    ent_t              m_e;
    logic              m_upd = 0, m_dir = 0, m_miss = 0, m_ras = 0, m_redir = 0, m_uf = 0;
    logic [31:0]       m_pc = 0, m_tgt = 0, m_rpc = 0;
    logic [META_W-1:0] m_meta = 0;
    logic              m_do_enq, m_do_res, m_mis;
    int                m_c, m_nc;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
            m_upd = 0; m_dir = 0; m_miss = 0; m_ras = 0; m_redir = 0; m_uf = 0;
            m_pc = 0; m_tgt = 0; m_rpc = 0; m_meta = 0;
        end else begin
            m_do_enq = enq_valid && (q.size() < DEPTH);
            m_do_res = res_valid && (q.size() > 0);
            m_mis    = 0;
            if (res_valid && q.size() == 0) m_uf = 1;
            m_upd = m_do_res; m_ras = 0; m_redir = 0;
            if (m_do_res) begin
                m_e   = q.pop_front();
                m_mis = (res_dir != m_e.dir) || (res_dir && res_target != m_e.tgt);
                m_c   = int'(m_e.meta[17:16]);
                m_nc  = res_dir ? ((m_c + 1 > 3) ? 3 : m_c + 1) : ((m_c == 0) ? 0 : m_c - 1);
                m_pc = m_e.pc; m_tgt = res_target; m_dir = res_dir; m_miss = m_mis;
                m_meta = {m_e.meta[21:18], 2'(m_nc), m_e.meta[15:0]};
                if (m_mis) begin
                    q.delete();
                    m_ras = 1; m_redir = 1; m_rpc = res_target;
                end
            end
            if (m_do_enq && !m_mis)
                q.push_back('{pc: enq_PC, dir: enq_p_dir, tgt: enq_p_target, meta: enq_meta});
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("update", 64'(execute_bpredictor_update), 64'(m_upd));
            chk("pc", 64'(execute_bpredictor_PC), 64'(m_pc));
            chk("target", 64'(execute_bpredictor_target), 64'(m_tgt));
            chk("dir", 64'(execute_bpredictor_dir), 64'(m_dir));
            chk("miss", 64'(execute_bpredictor_miss), 64'(m_miss));
            chk("meta", 64'(execute_bpredictor_meta), 64'(m_meta));
            chk("recover_ras", 64'(execute_bpredictor_recover_ras), 64'(m_ras));
            chk("redirect", 64'(fetch_redirect), 64'(m_redir));
            chk("redirect_pc", 64'(fetch_redirect_PC), 64'(m_rpc));
            chk("count", 64'(count), 64'(q.size()));
            chk("enq_ready", 64'(enq_ready), 64'(q.size() < DEPTH));
            chk("stall", 64'(soin_bpredictor_stall), 64'(q.size() == DEPTH));
            chk("underflow", 64'(res_underflow), 64'(m_uf));
        end
    end

    task automatic step(input logic ev, input logic [31:0] pc, input logic pd,
                        input logic [31:0] pt, input logic [META_W-1:0] m,
                        input logic rv, input logic rd, input logic [31:0] rt);
        enq_valid = ev; enq_PC = pc; enq_p_dir = pd; enq_p_target = pt; enq_meta = m;
        res_valid = rv; res_dir = rd; res_target = rt;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    logic [31:0] pc;

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 64'(enq_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_update", 64'(execute_bpredictor_update), 64'd0);
        chk("rst_redirect_pc", 64'(fetch_redirect_PC), 64'd0);
        idle();

        for (int i = 0; i < 3; i++) begin
            pc = 32'h10 + 32'(4 * i);
            step(1, pc, 0, pc + 32'd4, mk(0, 1, i), 0, 0, 0);
        end
        chk("nt_count3", 64'(count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            pc = 32'h10 + 32'(4 * i);
            step(0, 0, 0, 0, '0, 1, 0, pc + 32'd4);
            chk("nt_update", 64'(execute_bpredictor_update), 64'd1);
            chk("nt_miss", 64'(execute_bpredictor_miss), 64'd0);
            chk("nt_ctr", 64'(execute_bpredictor_meta[17:16]), 64'd0);
            chk("nt_count", 64'(count), 64'(2 - i));
        end
        idle();
        chk("nt_pulse_end", 64'(execute_bpredictor_update), 64'd0);

        for (int i = 0; i < 8; i++) begin
            pc = 32'h100 + 32'(4 * i);
            step(1, pc, 0, pc + 32'd4, mk(0, 2, i), 0, 0, 0);
        end
        chk("full_ready", 64'(enq_ready), 64'd0);
        chk("full_stall", 64'(soin_bpredictor_stall), 64'd1);
        step(1, 32'h999, 0, 32'h99d, mk(0, 2, 9), 0, 0, 0);
        chk("full_ignore", 64'(count), 64'd8);
        step(1, 32'h120, 0, 32'h124, mk(0, 2, 8), 1, 0, 32'h104);
        chk("full_res_pc", 64'(execute_bpredictor_PC), 64'h100);
        chk("full_res_count", 64'(count), 64'd7);
        chk("full_res_ready", 64'(enq_ready), 64'd1);
        step(1, 32'h120, 0, 32'h124, mk(0, 2, 8), 0, 0, 0);
        chk("wrap_count", 64'(count), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            pc = 32'h100 + 32'(4 * i);
            step(0, 0, 0, 0, '0, 1, 0, pc + 32'd4);
            chk("wrap_order", 64'(execute_bpredictor_PC), 64'(pc));
        end
        chk("wrap_ctr", 64'(execute_bpredictor_meta[17:16]), 64'd1);
        chk("wrap_empty", 64'(count), 64'd0);

        step(1, 32'h300, 1, 32'h200, mk(2, 3, 7), 0, 0, 0);
        step(1, 32'h304, 0, 32'h308, mk(2, 1, 8), 0, 0, 0);
        step(0, 0, 0, 0, '0, 1, 1, 32'h240);
        chk("mp_miss", 64'(execute_bpredictor_miss), 64'd1);
        chk("mp_ctr", 64'(execute_bpredictor_meta[17:16]), 64'd3);
        chk("mp_redirect", 64'(fetch_redirect), 64'd1);
        chk("mp_redirect_pc", 64'(fetch_redirect_PC), 64'h240);
        chk("mp_ras", 64'(execute_bpredictor_recover_ras), 64'd1);
        chk("mp_count", 64'(count), 64'd0);
        idle();
        chk("mp_redirect_end", 64'(fetch_redirect), 64'd0);
        chk("mp_pc_hold", 64'(fetch_redirect_PC), 64'h240);

        step(1, 32'h400, 0, 32'h404, mk(5, 0, 16'h55), 0, 0, 0);
        step(1, 32'h500, 0, 32'h504, mk(1, 1, 1), 1, 1, 32'h480);
        chk("se_miss", 64'(execute_bpredictor_miss), 64'd1);
        chk("se_meta", 64'(execute_bpredictor_meta), 64'(mk(5, 1, 16'h55)));
        chk("se_count", 64'(count), 64'd0);
        idle();

        step(1, 32'h600, 0, 32'h604, mk(1, 1, 1), 0, 0, 0);
        step(1, 32'h610, 0, 32'h614, mk(1, 1, 2), 1, 0, 32'h604);
        chk("sn_count", 64'(count), 64'd1);
        chk("sn_pc", 64'(execute_bpredictor_PC), 64'h600);
        step(0, 0, 0, 0, '0, 1, 0, 32'h614);
        chk("sn_pc2", 64'(execute_bpredictor_PC), 64'h610);

        step(0, 0, 0, 0, '0, 1, 1, 32'h700);
        chk("uf_update", 64'(execute_bpredictor_update), 64'd0);
        chk("uf_set", 64'(res_underflow), 64'd1);
        idle();
        chk("uf_sticky", 64'(res_underflow), 64'd1);

        for (int i = 0; i < 4; i++) begin
            pc = 32'h800 + 32'(4 * i);
            step(1, pc, 1, pc + 32'h40, mk(3, 2, i), 0, 0, 0);
        end
        idle();
        chk("ar_count4", 64'(count), 64'd4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_underflow", 64'(res_underflow), 64'd0);
        chk("ar_ready", 64'(enq_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        idle();
        step(1, 32'h900, 1, 32'h940, mk(1, 1, 3), 0, 0, 0);
        step(0, 0, 0, 0, '0, 1, 1, 32'h940);
        chk("post_pc", 64'(execute_bpredictor_PC), 64'h900);
        chk("post_ctr", 64'(execute_bpredictor_meta[17:16]), 64'd2);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
